fp_norm_sequencer: RTL and testbench

//  Shared multi-cycle normaliser for float32 add/sub results in the Maxnet neuron array.

---
 rtl/fp_norm_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_fp_norm_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_sequencer.sv
// Shared multi-cycle float32 normaliser with a round-robin front end over N_REQ requesters.
// Optional NORM_PERF_EN adds perf_ops / perf_busy counters.
module fp_norm_sequencer #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_exp,
    input  logic [25*N_REQ-1:0]  req_mant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_id,
    output logic [7:0]           out_exp,
    output logic [22:0]          out_mant,
    output logic                 busy
`ifdef NORM_PERF_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [31:0]          perf_busy
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] rrPtr_q, rrPtr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      exp_q, exp_d;
    logic [24:0]     mant_q, mant_d;

    logic [2*N_REQ-1:0] validDbl;
    logic [N_REQ-1:0]   validRot;
    logic [N_REQ-1:0]   probe;
    logic               grantFound;
    int                 grantOff;
    int                 grantSel;
    logic [ID_W-1:0]    grantIdx;
    logic [7:0]         expSel;
    logic [24:0]        mantSel;

    // Rotate the valid vector so the search always starts at rrPtr, then map back.
    always_comb begin
        validDbl   = {req_valid, req_valid};
        validRot   = N_REQ'(validDbl >> rrPtr_q);
        probe      = validRot;
        grantFound = 1'b0;
        grantOff   = 0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!grantFound && probe[0]) begin
                grantFound = 1'b1;
                grantOff   = off;
            end
            probe = probe >> 1;
        end
        grantSel = (int'(rrPtr_q) + grantOff) % N_REQ;
        grantIdx = ID_W'(grantSel);
        expSel   = 8'(req_exp >> (8 * grantSel));
        mantSel  = 25'(req_mant >> (25 * grantSel));
    end

    assign req_ready = (state_q == IDLE && grantFound) ? (N_REQ'(1) << grantIdx) : '0;

    logic [23:0] scan;
    int          lz;
    int          k;
    logic [24:0] mantShl;
    logic [7:0]  expShl;

    // One bounded left-shift step: never past the leading one and never below exponent 1.
    always_comb begin
        scan = mant_q[23:0];
        lz   = 24;
        for (int b = 0; b < 24; b++) begin
            if (lz == 24 && scan[23]) begin
                lz = b;
            end
            scan = scan << 1;
        end
        k = STEP;
        if (lz < k) begin
            k = lz;
        end
        if (int'(exp_q) - 1 < k) begin
            k = int'(exp_q) - 1;
        end
        if (k < 0) begin
            k = 0;
        end
        mantShl = mant_q << k;
        expShl  = exp_q - 8'(k);
    end

    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        id_d    = id_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        case (state_q)
            IDLE: begin
                if (grantFound) begin
                    exp_d   = expSel;
                    mant_d  = mantSel;
                    id_d    = grantIdx;
                    rrPtr_d = ID_W'((grantSel + 1) % N_REQ);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                state_d = DONE;
                if (exp_q == 8'hFF) begin
                    exp_d = exp_q;
                end else if (mant_q == 25'd0) begin
                    exp_d = 8'd0;
                end else if (mant_q[24]) begin
                    if (exp_q == 8'hFE) begin
                        exp_d  = 8'hFF;
                        mant_d = 25'd0;
                    end else begin
                        exp_d  = exp_q + 8'd1;
                        mant_d = mant_q >> 1;
                    end
                end else if (mant_q[23]) begin
                    exp_d = exp_q;
                end else if (exp_q <= 8'd1) begin
                    exp_d = 8'd0;
                end else begin
                    mant_d = mantShl;
                    exp_d  = expShl;
                    if (!mantShl[23]) begin
                        if (expShl == 8'd1) begin
                            exp_d = 8'd0;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rrPtr_q <= '0;
            id_q    <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
        end else begin
            state_q <= state_d;
            rrPtr_q <= rrPtr_d;
            id_q    <= id_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_id    = id_q;
    assign out_exp   = exp_q;
    assign out_mant  = mant_q[22:0];

`ifdef NORM_PERF_EN
    logic [31:0] perfOps_q, perfBusy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perfOps_q  <= '0;
            perfBusy_q <= '0;
        end else begin
            if (state_q == DONE && out_ready) begin
                perfOps_q <= perfOps_q + 32'd1;
            end
            if (busy) begin
                perfBusy_q <= perfBusy_q + 32'd1;
            end
        end
    end

    assign perf_ops  = perfOps_q;
    assign perf_busy = perfBusy_q;
`endif

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Self-checking bench for fp_norm_sequencer: directed corner cases plus randomized requests
// compared against an arithmetic reference model.
module tb_fp_norm_sequencer;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int STEP  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [8*N_REQ-1:0]   req_exp;
    logic [25*N_REQ-1:0]  req_mant;
    logic                 out_valid;
    logic                 out_ready;
    logic [ID_W-1:0]      out_id;
    logic [7:0]           out_exp;
    logic [22:0]          out_mant;
    logic                 busy;
`ifdef NORM_PERF_EN
    logic [31:0]          perf_ops;
    logic [31:0]          perf_busy;
`endif

    int compared   = 0;
    int mismatched = 0;

    fp_norm_sequencer #(.N_REQ(N_REQ), .ID_W(ID_W), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_exp   (req_exp),
        .req_mant  (req_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .busy      (busy)
`ifdef NORM_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_busy (perf_busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Whole-operation result: total shift is min(leading zeros, exp-1), paid STEP bits per cycle.
    task automatic refNorm(input logic [7:0] e, input logic [24:0] m,
                           output logic [7:0] re, output logic [22:0] rm, output int lat);
        int ei, lz, s;
        logic [24:0] mm;
        ei  = int'(e);
        lat = 2;
        mm  = m;
        if (e == 8'hFF) begin
            re = e;
            rm = m[22:0];
        end else if (m == 25'd0) begin
            re = 8'd0;
            rm = 23'd0;
        end else if (m[24]) begin
            if (e == 8'hFE) begin
                re = 8'hFF;
                rm = 23'd0;
            end else begin
                re = 8'(ei + 1);
                mm = m >> 1;
                rm = mm[22:0];
            end
        end else if (m[23]) begin
            re = e;
            rm = m[22:0];
        end else if (ei <= 1) begin
            re = 8'd0;
            rm = m[22:0];
        end else begin
            lz = 24 - $clog2(int'(m) + 1);
            if (lz <= ei - 1) begin
                s  = lz;
                re = 8'(ei - lz);
            end else begin
                s  = ei - 1;
                re = 8'd0;
            end
            mm  = m << s;
            rm  = mm[22:0];
            lat = 1 + (s + STEP - 1) / STEP;
        end
    endtask

    task automatic applyStimulus(input string tag, input int id, input logic [7:0] e,
                                 input logic [24:0] m, input int stall);
        logic [7:0]  re;
        logic [22:0] rm;
        int          lat, waitc, seen;
        bit          readyLeak;
        refNorm(e, m, re, rm, lat);
        @(negedge clk);
        req_exp[8*id +: 8]   = e;
        req_mant[25*id +: 25] = m;
        req_valid            = '0;
        req_valid[id]        = 1'b1;
        out_ready            = (stall == 0);
        #1;
        waitc = 0;
        while (!req_ready[id] && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        checkOutput({tag, "_grant"}, 32'(req_ready), 32'(N_REQ'(1) << id));
        seen      = 0;
        readyLeak = 1'b0;
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
            #1;
            if (req_ready != '0) readyLeak = 1'b1;
            if (out_valid) seen = c;
        end
        checkOutput({tag, "_latency"}, 32'(seen), 32'(lat));
        checkOutput({tag, "_exp"}, 32'(out_exp), 32'(re));
        checkOutput({tag, "_mant"}, 32'(out_mant), 32'(rm));
        checkOutput({tag, "_id"}, 32'(out_id), 32'(id));
        if (stall > 0) begin
            req_valid = '1;
            repeat (stall) @(negedge clk);
            #1;
            if (req_ready != '0) readyLeak = 1'b1;
            checkOutput({tag, "_held_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_held_exp"}, 32'(out_exp), 32'(re));
            checkOutput({tag, "_held_mant"}, 32'(out_mant), 32'(rm));
            checkOutput({tag, "_held_id"}, 32'(out_id), 32'(id));
            @(negedge clk);
            req_valid = '0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_released"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ready_leak"}, 32'(readyLeak), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          waitc;
        bit          leak;
        bit          spurious;
        int          expIds[4];
        logic [7:0]  e;
        logic [24:0] m;
        int          id, stall;

        rst       = 1'b1;
        req_valid = '0;
        req_exp   = '0;
        req_mant  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_out_exp", 32'(out_exp), 32'd0);
        checkOutput("reset_out_mant", 32'(out_mant), 32'd0);
        checkOutput("reset_out_id", 32'(out_id), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Two requesters valid straight out of reset must alternate 0,2,0,2.
        @(negedge clk);
        rst                = 1'b1;
        req_exp[7:0]       = 8'h10;
        req_mant[24:0]     = 25'h0800000;
        req_exp[23:16]     = 8'h30;
        req_mant[74:50]    = 25'h0800000;
        req_valid          = 4'b0101;
        out_ready          = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        expIds = '{0, 2, 0, 2};
        leak   = 1'b0;
        for (int r = 0; r < 4; r++) begin
            waitc = 0;
            do begin
                @(negedge clk);
                #1;
                if (busy && req_ready != '0) leak = 1'b1;
                waitc++;
            end while (!out_valid && waitc < 10);
            checkOutput($sformatf("rr_id%0d", r), 32'(out_id), 32'(expIds[r]));
            checkOutput($sformatf("rr_exp%0d", r), 32'(out_exp), (expIds[r] == 0) ? 32'h10 : 32'h30);
        end
        @(negedge clk);
        req_valid = '0;
        checkOutput("rr_ready_outside_idle", 32'(leak), 32'd0);
        repeat (2) @(negedge clk);

        // Reset while shifting: no result, pointer back to 0.
        req_exp[15:8]   = 8'h90;
        req_mant[49:25] = 25'h0002000;
        req_valid       = 4'b0010;
        #1;
        waitc = 0;
        while (!req_ready[1] && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        checkOutput("rst_mid_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        #1;
        checkOutput("rst_mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_busy_after", 32'(busy), 32'd0);
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_out_exp", 32'(out_exp), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        spurious = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid) spurious = 1'b1;
        end
        checkOutput("rst_mid_no_result", 32'(spurious), 32'd0);
        req_valid = 4'b1001;
        #1;
        checkOutput("rst_mid_rr_ptr", 32'(req_ready), 32'h1);
        req_valid = '0;

        applyStimulus("normal", 0, 8'h80, 25'h0800000, 0);
        applyStimulus("carry", 1, 8'h7F, 25'h1000001, 0);
        applyStimulus("overflow", 2, 8'hFE, 25'h1800000, 0);
        applyStimulus("lz10", 3, 8'h90, 25'h0002000, 0);
        applyStimulus("zero", 0, 8'h55, 25'h0000000, 0);
        applyStimulus("underflow", 1, 8'h03, 25'h0000100, 0);
        applyStimulus("stall", 2, 8'h40, 25'h0400000, 5);
        applyStimulus("exp255", 3, 8'hFF, 25'h0123456, 0);
        applyStimulus("denorm_in", 0, 8'h01, 25'h0001234, 0);
        applyStimulus("exact_one", 1, 8'h05, 25'h0080000, 0);

        for (int t = 0; t < 80; t++) begin
            id = $urandom_range(0, N_REQ - 1);
            case ($urandom_range(0, 7))
                0:       e = 8'($urandom_range(0, 6));
                1:       e = 8'($urandom_range(254, 255));
                default: e = 8'($urandom_range(0, 255));
            endcase
            m = 25'($urandom) >> $urandom_range(0, 24);
            stall = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            applyStimulus($sformatf("rand%0d", t), id, e, m, stall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
